sweep_count_ctrl: RTL

//  Sequencer for the up/down counter datapath: owns a WIDTH-bit counter and its direction.

---
 rtl/sweep_count_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sweep_count_ctrl.sv
// Sweep sequencer: drives a bounded up/down counter lo->hi->lo with programmable
// dwell at each end, a sweep-count limit, and start/stop/done/err host handshake.
module sweep_count_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] cycles,
  output logic [WIDTH-1:0]   count,
  output logic               direction,
  output logic               busy,
  output logic [SWEEP_W-1:0] sweeps,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DWELL_HI,
    S_DOWN,
    S_DWELL_LO,
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [WIDTH-1:0]   r_count, w_count;
  logic               r_dir, w_dir;
  logic [SWEEP_W-1:0] r_sweeps, w_sweeps;
  logic [DWELL_W-1:0] r_timer, w_timer;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               w_latch;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic [DWELL_W-1:0] r_dwell;
  logic [SWEEP_W-1:0] r_cycles;
  logic [SWEEP_W-1:0] w_sweeps_inc;

  assign w_sweeps_inc = r_sweeps + SWEEP_W'(1);

  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_dir    = r_dir;
    w_sweeps = r_sweeps;
    w_timer  = r_timer;
    w_done   = 1'b0;
    w_err    = 1'b0;
    w_latch  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            w_latch  = 1'b1;
            w_count  = lo;
            w_dir    = 1'b1;
            w_sweeps = '0;
            w_state  = S_UP;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_UP: begin
        if (r_count < r_hi) begin
          w_count = r_count + WIDTH'(1);
        end else if (r_dwell == '0) begin
          w_state = S_DOWN;
          w_dir   = 1'b0;
        end else begin
          w_timer = r_dwell;
          w_state = S_DWELL_HI;
        end
      end
      S_DWELL_HI: begin
        w_timer = r_timer - DWELL_W'(1);
        if (r_timer == DWELL_W'(1)) begin
          w_state = S_DOWN;
          w_dir   = 1'b0;
        end
      end
      S_DOWN: begin
        if (r_count > r_lo) begin
          w_count = r_count - WIDTH'(1);
        end else begin
          // A sweep completes on arrival at lo; the limit is tested on the new total.
          w_sweeps = w_sweeps_inc;
          if ((r_cycles != '0) && (w_sweeps_inc == r_cycles)) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else if (r_dwell == '0) begin
            w_state = S_UP;
            w_dir   = 1'b1;
          end else begin
            w_timer = r_dwell;
            w_state = S_DWELL_LO;
          end
        end
      end
      S_DWELL_LO: begin
        w_timer = r_timer - DWELL_W'(1);
        if (r_timer == DWELL_W'(1)) begin
          w_state = S_UP;
          w_dir   = 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    // Abort freezes the datapath where it is and suppresses completion.
    if (stop && (r_state != S_IDLE)) begin
      w_state  = S_IDLE;
      w_count  = r_count;
      w_dir    = r_dir;
      w_sweeps = r_sweeps;
      w_timer  = r_timer;
      w_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_dir    <= 1'b1;
      r_sweeps <= '0;
      r_timer  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_dwell  <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_dir    <= w_dir;
      r_sweeps <= w_sweeps;
      r_timer  <= w_timer;
      r_done   <= w_done;
      r_err    <= w_err;
      if (w_latch) begin
        r_lo     <= lo;
        r_hi     <= hi;
        r_dwell  <= dwell;
        r_cycles <= cycles;
      end
    end
  end

  assign count     = r_count;
  assign direction = r_dir;
  assign busy      = (r_state != S_IDLE);
  assign sweeps    = r_sweeps;
  assign done      = r_done;
  assign err       = r_err;

endmodule
